calibration_ram_dbuf: RTL and testbench
=======================================

CALIBRATION_RAM_DBUF -- requirements
Module: calibration_ram_dbuf

Interface
REQ-001 SHALL have parameter DATA_W, default 16, coefficient width in bits (multiple of 8).
REQ-002 SHALL have parameter NUM_CH, default 320, number of calibration channels (2..4096).
REQ-003 SHALL derive CH_W = clog2(NUM_CH), BE_W = DATA_W/8, AV_AW = CH_W+1.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  sole clock; reset  in  1  synchronous active-high reset.
REQ-005 SHALL have avs_address  in  AV_AW  bit AV_AW-1 = 0 selects a shadow RAM word, 1 selects a register.
REQ-006 SHALL have avs_chipselect, avs_read, avs_write  in  1 each  Avalon-MM slave controls.
REQ-007 SHALL have avs_byteenable  in  BE_W and avs_writedata  in  DATA_W.
REQ-008 SHALL have avs_readdata  out  DATA_W and avs_waitrequest  out  1.
REQ-009 SHALL have lk_valid  in  1 and lk_channel  in  CH_W  coefficient lookup request.
REQ-010 SHALL have lk_out_valid  out  1, lk_coef  out  DATA_W, and lk_err  out  1  lookup result.
REQ-011 SHALL have frame_sync  in  1  single-cycle frame boundary pulse.
REQ-012 SHALL have swap_irq  out  1  single-cycle pulse when a bank swap completes.

Function
REQ-013 SHALL hold 2 banks of NUM_CH words; active_bank feeds lookups, and the other bank is the shadow bank.
REQ-014 A CPU RAM access SHALL target shadow-bank word avs_address[CH_W-1:0], with per-byte writes gated by avs_byteenable.
REQ-015 A CPU RAM index >= NUM_CH SHALL not write and SHALL read 0.
REQ-016 CPU reads SHALL have a fixed read latency of 1 cycle (avs_readdata valid the cycle after the accepted read).
REQ-017 Register 0 (CTRL, write): bit0=1 SHALL request a swap; bit1=1 SHALL start a copy of active to shadow; other bits are ignored.
REQ-018 Register 1 (STATUS, read): bit0 swap_pending, bit1 copy_busy, bit2 active_bank, and the rest 0.
REQ-019 The swap FSM SHALL have states IDLE -> PENDING on a swap request, and PENDING -> IDLE on frame_sync while copy_busy=0, toggling active_bank and pulsing swap_irq in the next cycle.
REQ-020 frame_sync in the same cycle as the CTRL swap write SHALL NOT swap; only a later frame_sync SHALL swap.
REQ-021 A swap request while PENDING SHALL be ignored, leaving exactly one pending swap.
REQ-022 The copy FSM SHALL have states IDLE -> RD -> WR -> RD ... for indices 0..NUM_CH-1, then IDLE, taking exactly 2*NUM_CH cycles after start.
REQ-023 A copy start while copy_busy=1 SHALL be ignored.
REQ-024 While copy_busy=1, avs_waitrequest SHALL be asserted for RAM-region accesses; register accesses SHALL never wait.
REQ-025 A lookup SHALL have latency 2: lk_out_valid is asserted 2 cycles after lk_valid, fully pipelined at 1 lookup per cycle.
REQ-026 A lookup SHALL use the active_bank value sampled in its issue cycle, so lookups in flight across a swap return old-bank data.
REQ-027 lk_channel >= NUM_CH SHALL return lk_coef=0 and lk_err=1 with lk_out_valid; otherwise lk_err=0.
REQ-028 lk_coef and lk_err SHALL hold their last values when lk_out_valid=0.

Reset
REQ-029 Reset SHALL set active_bank=0, both FSMs to IDLE, and swap_irq, lk_out_valid, lk_err, avs_waitrequest, avs_readdata, and lk_coef to 0.
REQ-030 Reset SHALL NOT clear RAM contents.
REQ-031 Reset during a copy SHALL abort it, leaving the shadow bank partially copied.
REQ-032 Reset SHALL drop a pending swap and flush the lookup pipeline.

Structure
REQ-033 A shared package calib_pkg SHALL hold the register offsets (CTRL=0, STATUS=1), the CTRL/STATUS bit positions, and the swap/copy FSM state enums.
REQ-034 The storage SHALL be one sub-module calib_dpram (true dual-port, byte-enabled, 2*NUM_CH x DATA_W, registered read).
REQ-035 In calib_dpram, port A SHALL serve CPU and copy traffic, and port B SHALL serve lookups.

Verification
REQ-036 Reset, then CPU write 0xBEEF to word 5 with be=2'b01, then read word 5 -> readdata low byte 0xEF one cycle later.
REQ-037 Shadow word 3=0x1234, swap request, frame_sync 10 cycles later -> swap_irq one cycle after that; lookup ch 3 -> lk_coef=0x1234 two cycles later.
REQ-038 Swap pending, lookup ch 3 issued in the frame_sync cycle -> old-bank value returned; lookup ch 3 issued the next cycle -> new-bank value returned.
REQ-039 Copy start with NUM_CH=320 -> copy_busy high for exactly 640 cycles; a CPU RAM read is stalled until then; the shadow bank equals the active bank afterwards.
REQ-040 Lookup ch 320 with NUM_CH=320 -> lk_err=1 and lk_coef=0; CPU write to word 320 leaves the RAM unchanged.
REQ-041 Reset asserted mid-copy at index 100 -> copy_busy=0, swap_pending=0, and active_bank=0 in the cycle after reset.

Source files
------------

// File: rtl/calib_pkg.sv
`default_nettype none
// calib_pkg: register map, CTRL/STATUS bit positions and FSM encodings shared by
// the calibration double-buffer RAM.
package calib_pkg;

  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;

  localparam int CTRL_SWAP_BIT = 0;
  localparam int CTRL_COPY_BIT = 1;

  localparam int STAT_PEND_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_BANK_BIT = 2;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  typedef enum logic [1:0] {
    COPY_IDLE = 2'd0,
    COPY_RD   = 2'd1,
    COPY_WR   = 2'd2
  } copy_state_e;

  function automatic logic [2:0] status_bits(input logic pend, input logic busy, input logic bank);
    logic [2:0] s;
    s                = '0;
    s[STAT_PEND_BIT] = pend;
    s[STAT_BUSY_BIT] = busy;
    s[STAT_BANK_BIT] = bank;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/calib_dpram.sv
`default_nettype none
// calib_dpram: dual-port byte-enabled coefficient RAM with registered reads.
// Port A reads and writes (CPU and copy engine); port B reads (lookups).
module calib_dpram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 640,
  parameter int AW     = 10,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              a_en_i,
  input  logic              a_we_i,
  input  logic [BE_W-1:0]   a_be_i,
  input  logic [AW-1:0]     a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_en_i,
  input  logic [AW-1:0]     b_addr_i,
  output logic [DATA_W-1:0] b_rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Read-before-write on port A: the copy engine relies on a plain registered read.
  always_ff @(posedge clk) begin
    if (a_en_i) begin
      if (a_we_i) begin
        for (int i = 0; i < BE_W; i++) begin
          if (a_be_i[i]) mem_q[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
        end
      end
      a_rdata_q <= mem_q[a_addr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (b_en_i) b_rdata_q <= mem_q[b_addr_i];
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule
`default_nettype wire

// File: rtl/calibration_ram_dbuf.sv
`default_nettype none
// calibration_ram_dbuf: double-buffered calibration coefficient RAM with an Avalon-MM
// CPU port on the shadow bank, frame-synchronous bank swap, bank copy engine and lookup pipe.
module calibration_ram_dbuf
  import calib_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 320,
  localparam int CH_W  = $clog2(NUM_CH),
  localparam int BE_W  = DATA_W / 8,
  localparam int AV_AW = CH_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AV_AW-1:0]  avs_address,
  input  logic              avs_chipselect,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [BE_W-1:0]   avs_byteenable,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  input  logic              lk_valid,
  input  logic [CH_W-1:0]   lk_channel,
  output logic              lk_out_valid,
  output logic [DATA_W-1:0] lk_coef,
  output logic              lk_err,
  input  logic              frame_sync,
  output logic              swap_irq
);

  localparam int RAM_AW = CH_W + 1;
  localparam logic [1:0] RS_ZERO = 2'd0;
  localparam logic [1:0] RS_RAM  = 2'd1;
  localparam logic [1:0] RS_REG  = 2'd2;

  // Bank b occupies physical words [b*NUM_CH, b*NUM_CH + NUM_CH).
  function automatic logic [RAM_AW-1:0] word_addr(input logic bank, input logic [CH_W-1:0] ch);
    return bank ? RAM_AW'(NUM_CH) + RAM_AW'(ch) : RAM_AW'(ch);
  endfunction

  swap_state_e       swap_q;
  copy_state_e       copy_q;
  logic              active_q;
  logic [CH_W-1:0]   cidx_q;
  logic              swap_irq_q;
  logic [1:0]        rsel_q;
  logic [DATA_W-1:0] rreg_q;
  logic              lk_v1_q, lk_e1_q;
  logic              lk_out_valid_q, lk_err_q;
  logic [DATA_W-1:0] lk_coef_q;

  logic [CH_W-1:0]   cpu_idx;
  logic              is_reg, idx_ok, copy_busy;
  logic              ram_rd_ok, ram_wr_ok, reg_rd, ctrl_wr, swap_req, copy_req;
  logic [DATA_W-1:0] status_w;
  logic              pa_en, pa_we;
  logic [BE_W-1:0]   pa_be;
  logic [RAM_AW-1:0] pa_addr, pb_addr;
  logic [DATA_W-1:0] pa_wdata, pa_rdata, pb_rdata;
  logic              lk_ok;
  logic              unused_wdata;

  assign cpu_idx   = avs_address[CH_W-1:0];
  assign is_reg    = avs_address[AV_AW-1];
  assign idx_ok    = int'(cpu_idx) < NUM_CH;
  assign copy_busy = (copy_q != COPY_IDLE);

  assign avs_waitrequest = avs_chipselect & (avs_read | avs_write) & ~is_reg & copy_busy & ~reset;
  assign ram_rd_ok = avs_chipselect & avs_read  & ~is_reg & ~copy_busy;
  assign ram_wr_ok = avs_chipselect & avs_write & ~is_reg & ~copy_busy & idx_ok;
  assign reg_rd    = avs_chipselect & avs_read  & is_reg;
  assign ctrl_wr   = avs_chipselect & avs_write & is_reg & (cpu_idx == CH_W'(REG_CTRL));
  assign swap_req  = ctrl_wr & avs_writedata[CTRL_SWAP_BIT];
  assign copy_req  = ctrl_wr & avs_writedata[CTRL_COPY_BIT];
  assign status_w  = DATA_W'(status_bits(swap_q == SWAP_PENDING, copy_busy, active_q));
  assign unused_wdata = ^avs_writedata[DATA_W-1:2];

  // Port A belongs to the copy engine while it runs; CPU RAM traffic is stalled meanwhile.
  always_comb begin
    pa_en    = 1'b0;
    pa_we    = 1'b0;
    pa_be    = '0;
    pa_addr  = '0;
    pa_wdata = '0;
    case (copy_q)
      COPY_RD: begin
        pa_en   = 1'b1;
        pa_addr = word_addr(active_q, cidx_q);
      end
      COPY_WR: begin
        pa_en    = 1'b1;
        pa_we    = 1'b1;
        pa_be    = '1;
        pa_addr  = word_addr(~active_q, cidx_q);
        pa_wdata = pa_rdata;
      end
      default: begin
        if (ram_rd_ok || ram_wr_ok) begin
          pa_en    = 1'b1;
          pa_we    = ram_wr_ok;
          pa_be    = avs_byteenable;
          pa_addr  = word_addr(~active_q, idx_ok ? cpu_idx : '0);
          pa_wdata = avs_writedata;
        end
      end
    endcase
  end

  assign lk_ok   = int'(lk_channel) < NUM_CH;
  assign pb_addr = word_addr(active_q, lk_ok ? lk_channel : '0);

  calib_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (2 * NUM_CH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk       (clk),
    .a_en_i    (pa_en),
    .a_we_i    (pa_we),
    .a_be_i    (pa_be),
    .a_addr_i  (pa_addr),
    .a_wdata_i (pa_wdata),
    .a_rdata_o (pa_rdata),
    .b_en_i    (lk_valid & lk_ok),
    .b_addr_i  (pb_addr),
    .b_rdata_o (pb_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      swap_q     <= SWAP_IDLE;
      active_q   <= 1'b0;
      swap_irq_q <= 1'b0;
    end else begin
      swap_irq_q <= 1'b0;
      case (swap_q)
        SWAP_IDLE:    if (swap_req) swap_q <= SWAP_PENDING;
        SWAP_PENDING: begin
          if (frame_sync && !copy_busy) begin
            swap_q     <= SWAP_IDLE;
            active_q   <= ~active_q;
            swap_irq_q <= 1'b1;
          end
        end
        default:      swap_q <= SWAP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      copy_q <= COPY_IDLE;
      cidx_q <= '0;
    end else begin
      case (copy_q)
        COPY_IDLE: begin
          if (copy_req) begin
            copy_q <= COPY_RD;
            cidx_q <= '0;
          end
        end
        COPY_RD: copy_q <= COPY_WR;
        COPY_WR: begin
          if (int'(cidx_q) == NUM_CH - 1) begin
            copy_q <= COPY_IDLE;
          end else begin
            copy_q <= COPY_RD;
            cidx_q <= cidx_q + 1'b1;
          end
        end
        default: copy_q <= COPY_IDLE;
      endcase
    end
  end

  // Read data source is chosen one cycle ahead; out-of-range RAM reads return zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsel_q <= RS_ZERO;
      rreg_q <= '0;
    end else begin
      rsel_q <= RS_ZERO;
      if (ram_rd_ok && idx_ok) rsel_q <= RS_RAM;
      if (reg_rd) begin
        rsel_q <= RS_REG;
        rreg_q <= (cpu_idx == CH_W'(REG_STATUS)) ? status_w : '0;
      end
    end
  end

  assign avs_readdata = (rsel_q == RS_RAM) ? pa_rdata :
                        (rsel_q == RS_REG) ? rreg_q   : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      lk_v1_q        <= 1'b0;
      lk_e1_q        <= 1'b0;
      lk_out_valid_q <= 1'b0;
      lk_err_q       <= 1'b0;
      lk_coef_q      <= '0;
    end else begin
      lk_v1_q        <= lk_valid;
      lk_e1_q        <= ~lk_ok;
      lk_out_valid_q <= lk_v1_q;
      if (lk_v1_q) begin
        lk_err_q  <= lk_e1_q;
        lk_coef_q <= lk_e1_q ? '0 : pb_rdata;
      end
    end
  end

  assign lk_out_valid = lk_out_valid_q;
  assign lk_coef      = lk_coef_q;
  assign lk_err       = lk_err_q;
  assign swap_irq     = swap_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_calibration_ram_dbuf.sv
`default_nettype none
// tb_calibration_ram_dbuf: directed stimulus; CPU reads, lookups and swap IRQs are
// checked by independent monitors popping expectation queues.
module tb_calibration_ram_dbuf;

  localparam int DATA_W = 16;
  localparam int NUM_CH = 320;
  localparam int CH_W   = 9;
  localparam int AV_AW  = 10;
  localparam logic [AV_AW-1:0] A_CTRL = 10'h200;
  localparam logic [AV_AW-1:0] A_STAT = 10'h201;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [AV_AW-1:0]  avs_address = '0;
  logic              avs_chipselect = 1'b0, avs_read = 1'b0, avs_write = 1'b0;
  logic [1:0]        avs_byteenable = '0;
  logic [DATA_W-1:0] avs_writedata = '0;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;
  logic              lk_valid = 1'b0;
  logic [CH_W-1:0]   lk_channel = '0;
  logic              lk_out_valid;
  logic [DATA_W-1:0] lk_coef;
  logic              lk_err;
  logic              frame_sync = 1'b0;
  logic              swap_irq;

  always #5 clk = ~clk;

  calibration_ram_dbuf #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
    .clk             (clk),
    .reset           (reset),
    .avs_address     (avs_address),
    .avs_chipselect  (avs_chipselect),
    .avs_read        (avs_read),
    .avs_write       (avs_write),
    .avs_byteenable  (avs_byteenable),
    .avs_writedata   (avs_writedata),
    .avs_readdata    (avs_readdata),
    .avs_waitrequest (avs_waitrequest),
    .lk_valid        (lk_valid),
    .lk_channel      (lk_channel),
    .lk_out_valid    (lk_out_valid),
    .lk_coef         (lk_coef),
    .lk_err          (lk_err),
    .frame_sync      (frame_sync),
    .swap_irq        (swap_irq)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] coef;
    logic        err;
    int          cyc;
  } lk_exp_t;

  logic [15:0] rd_q[$];
  lk_exp_t     lk_q[$];
  int          irq_q[$];
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] p1(input int i);
    return (i == 3) ? 16'h1234 : 16'hA000 + 16'(i);
  endfunction

  function automatic logic [15:0] p0(input int i);
    return 16'hB000 + 16'(i);
  endfunction

  // CPU read monitor: data is due the cycle after an accepted read.
  bit rd_acc_prev = 1'b0;
  always @(negedge clk) begin
    logic [15:0] e;
    if (rd_acc_prev && rd_q.size() > 0) begin
      e = rd_q.pop_front();
      check("rd_data", 32'(avs_readdata), 32'(e));
    end
    rd_acc_prev = avs_chipselect && avs_read && !avs_waitrequest && !reset;
  end

  // Lookup monitor: data, error flag, latency, and hold while not valid.
  logic [15:0] last_coef = '0;
  logic        last_err  = 1'b0;
  always @(negedge clk) begin
    lk_exp_t e;
    if (mon_en) begin
      if (lk_out_valid) begin
        if (lk_q.size() > 0) begin
          e = lk_q.pop_front();
          check("lk_coef", 32'(lk_coef), 32'(e.coef));
          check("lk_err", 32'(lk_err), 32'(e.err));
          check("lk_latency", cyc, e.cyc);
          last_coef = e.coef;
          last_err  = e.err;
        end else begin
          check("lk_spurious", 32'(lk_out_valid), 32'(0));
        end
      end else begin
        check("lk_hold", {15'd0, lk_err, lk_coef}, {15'd0, last_err, last_coef});
      end
    end
    if (reset) begin
      last_coef = '0;
      last_err  = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en && swap_irq) begin
      if (irq_q.size() > 0) check("irq_cycle", cyc, irq_q.pop_front());
      else check("irq_spurious", 32'(swap_irq), 32'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic wr, input logic [AV_AW-1:0] a, input logic [15:0] wd,
                     input logic [1:0] be, output int acc);
    int n;
    n = 0;
    avs_chipselect = 1'b1;
    avs_read       = ~wr;
    avs_write      = wr;
    avs_address    = a;
    avs_writedata  = wd;
    avs_byteenable = be;
    #1;
    while (avs_waitrequest && n < 4000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 4000) check("bus_timeout", 32'(avs_waitrequest), 32'(0));
    acc = cyc;
    @(posedge clk);
    #1;
    avs_chipselect = 1'b0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
  endtask

  task automatic cpu_write(input logic [AV_AW-1:0] a, input logic [15:0] d, input logic [1:0] be,
                           output int acc);
    bus(1'b1, a, d, be, acc);
  endtask

  task automatic cpu_read(input logic [AV_AW-1:0] a, input logic [15:0] exp, output int acc);
    rd_q.push_back(exp);
    bus(1'b0, a, 16'h0, 2'b00, acc);
  endtask

  task automatic lookup(input int ch, input logic [15:0] exp, input logic err, input bit expect_out);
    lk_valid   = 1'b1;
    lk_channel = CH_W'(ch);
    if (expect_out) lk_q.push_back('{coef: exp, err: err, cyc: cyc + 2});
    tick();
    lk_valid = 1'b0;
  endtask

  task automatic pulse_frame(input bit expect_irq);
    frame_sync = 1'b1;
    if (expect_irq) irq_q.push_back(cyc + 1);
    tick();
    frame_sync = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 100000", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, r, s;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_lk_out_valid", 32'(lk_out_valid), 32'(0));
    check("rst_lk_coef", 32'(lk_coef), 32'(0));
    check("rst_lk_err", 32'(lk_err), 32'(0));
    check("rst_swap_irq", 32'(swap_irq), 32'(0));
    check("rst_waitrequest", 32'(avs_waitrequest), 32'(0));
    check("rst_readdata", 32'(avs_readdata), 32'(0));
    mon_en = 1'b1;
    tick();
    cpu_read(A_STAT, 16'h0000, acc);

    // Byte-enable gating on shadow word 5
    cpu_write(10'd5, 16'h0000, 2'b11, acc);
    cpu_write(10'd5, 16'hBEEF, 2'b01, acc);
    cpu_read(10'd5, 16'h00EF, acc);
    cpu_write(10'd5, 16'h1234, 2'b10, acc);
    cpu_read(10'd5, 16'h12EF, acc);

    for (int i = 0; i < NUM_CH; i++) cpu_write(AV_AW'(i), p1(i), 2'b11, acc);

    // Swap 1: frame_sync ten cycles after the request
    cpu_write(A_CTRL, 16'h0001, 2'b11, r);
    cpu_read(A_STAT, 16'h0001, acc);
    while (cyc < r + 10) tick();
    pulse_frame(1'b1);
    lookup(3, 16'h1234, 1'b0, 1'b1);
    cpu_read(A_STAT, 16'h0004, acc);

    // Out-of-range CPU and lookup accesses
    cpu_write(10'd320, 16'hDEAD, 2'b11, acc);
    cpu_read(10'd320, 16'h0000, acc);
    lookup(0, 16'hA000, 1'b0, 1'b1);
    lookup(320, 16'h0000, 1'b1, 1'b1);
    lookup(319, 16'hA13F, 1'b0, 1'b1);
    lookup(5, 16'hA005, 1'b0, 1'b1);
    repeat (3) tick();

    for (int i = 0; i < NUM_CH; i++) cpu_write(AV_AW'(i), p0(i), 2'b11, acc);

    // Swap 2: duplicate request ignored; in-flight lookup keeps old bank
    cpu_write(A_CTRL, 16'h0001, 2'b11, acc);
    cpu_write(A_CTRL, 16'h0001, 2'b11, acc);
    cpu_read(A_STAT, 16'h0005, acc);
    lk_valid   = 1'b1;
    lk_channel = 9'd3;
    lk_q.push_back('{coef: 16'h1234, err: 1'b0, cyc: cyc + 2});
    pulse_frame(1'b1);
    lk_valid = 1'b0;
    lookup(3, 16'hB003, 1'b0, 1'b1);
    cpu_read(A_STAT, 16'h0000, acc);
    repeat (3) tick();

    // Swap 3: frame_sync coincident with the request does not swap
    frame_sync = 1'b1;
    cpu_write(A_CTRL, 16'h0001, 2'b11, acc);
    frame_sync = 1'b0;
    cpu_read(A_STAT, 16'h0001, acc);
    pulse_frame(1'b1);
    cpu_read(A_STAT, 16'h0004, acc);

    // Copy active (bank 1) to shadow (bank 0); restart while busy is ignored
    cpu_write(A_CTRL, 16'h0002, 2'b11, s);
    cpu_write(A_CTRL, 16'h0002, 2'b11, acc);
    cpu_read(A_STAT, 16'h0006, acc);
    cpu_read(10'd7, 16'hA007, acc);
    check("copy_stall_release", acc, s + 641);
    for (int i = 0; i < NUM_CH; i++) cpu_read(AV_AW'(i), p1(i), acc);
    lookup(3, 16'h1234, 1'b0, 1'b1);

    // Reset mid-copy at index 100 with a swap pending and a lookup in flight
    cpu_write(A_CTRL, 16'h0001, 2'b11, acc);
    cpu_write(A_CTRL, 16'h0002, 2'b11, s);
    while (cyc < s + 200) tick();
    lookup(1, 16'h0000, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_read(A_STAT, 16'h0000, acc);
    lookup(2, 16'hA002, 1'b0, 1'b1);

    repeat (6) tick();
    check("rd_queue_drained", rd_q.size(), 0);
    check("lk_queue_drained", lk_q.size(), 0);
    check("irq_queue_drained", irq_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
